// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake interface into
// AW/W/B writes and AR/R reads, with a per-state timeout that aborts hung transfers.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int unsigned        TIMER_W    = 16;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                rsp_write_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_timeout_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic                awvalid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wvalid_q;
  logic                bready_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic                arvalid_q;
  logic                rready_q;

  logic timer_exp_c;
  logic aw_fin_c;
  logic w_fin_c;

  // A channel is finished once its handshake has happened, including on this edge
  assign timer_exp_c = (timer_q == TIMER_LAST);
  assign aw_fin_c    = aw_done_q | (awvalid_q & AWREADY);
  assign w_fin_c     = w_done_q  | (wvalid_q  & WREADY);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      awaddr_q      <= '0;
      awvalid_q     <= 1'b0;
      wdata_q       <= '0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          timer_q     <= '0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rsp_write_q <= cmd_write;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (aw_fin_c && w_fin_c) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            timer_q   <= '0;
            state_q   <= WR_RESP;
          end else if (timer_exp_c) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= RSP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
            if (awvalid_q && AWREADY) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (wvalid_q && WREADY) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
          end
        end

        WR_RESP: begin
          if (BVALID || timer_exp_c) begin
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= ~BVALID;
            state_q       <= RSP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        RD_REQ: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            timer_q   <= '0;
            state_q   <= RD_DATA;
          end else if (timer_exp_c) begin
            arvalid_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= RSP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        RD_DATA: begin
          if (RVALID || timer_exp_c) begin
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= RVALID ? RDATA : '0;
            rsp_timeout_q <= ~RVALID;
            state_q       <= RSP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        RSP: begin
          // Response fields stay frozen until the consumer takes them
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

endmodule
